chunk_adder_seq: RTL and testbench



---
 rtl/chunk_adder_seq.sv | 78 +++++++
 tb/tb_chunk_adder_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/chunk_adder_seq.sv
// chunk_adder_seq: WIDTH-bit A+B+cin computed CHUNK bits per cycle on one reused slice; define CHUNK_ADDER_SEQ_OVF_EN to add signed-overflow output ovf
module chunk_adder_seq #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNK_ADDER_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   add;
  logic             last;
  assign a_c       = a_r[idx*CHUNK +: CHUNK];
  assign b_c       = b_r[idx*CHUNK +: CHUNK];
  assign add       = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(carry_r);
  assign last      = idx == IW'(NCHUNK - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: accept in IDLE, step chunks in RUN, hold result until taken
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  end
  // operand capture and one slice add per RUN cycle, carry fed back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CHUNK_ADDER_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum[idx*CHUNK +: CHUNK] <= add[CHUNK-1:0];
      carry_r <= add[CHUNK];
      idx     <= idx + 1'b1;
      if (last) begin
        cout <= add[CHUNK];
`ifdef CHUNK_ADDER_SEQ_OVF_EN
        ovf  <= a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ add[CHUNK-1] ^ add[CHUNK];
`endif
      end
    end
  end
endmodule

// File: tb/tb_chunk_adder_seq.sv
// tb_chunk_adder_seq: scoreboard bench for chunk_adder_seq at WIDTH=12, CHUNK=3
module tb_chunk_adder_seq;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin = 0;
  logic [11:0] a = 0, b = 0, sum;
  logic        in_ready, out_valid, cout;
  logic        ovf;
  typedef struct { logic [11:0] s; logic c; logic o; } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  chunk_adder_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CHUNK_ADDER_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef CHUNK_ADDER_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic push_exp(input logic [11:0] av, bv, input logic ci);
    exp_t e;
    logic [12:0] t;
    t = {1'b0, av} + {1'b0, bv} + {12'd0, ci};
    e.s = t[11:0];
    e.c = t[12];
    e.o = (av[11] == bv[11]) && (t[11] != av[11]);
    exp_q.push_back(e);
  endtask
  task automatic send(input logic [11:0] av, bv, input logic ci, output int lat);
    for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
    a = av; b = bv; cin = ci; in_valid = 1;
    push_exp(av, bv, ci);
    @(posedge clk); #1;
    in_valid = 0; a = ~av; b = ~bv; cin = ~ci;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic test_reset;
    rst = 1;
    #3;
    vectors++;
    if ({out_valid, sum, cout, ovf} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b want 0", out_valid, sum, cout, ovf);
    end
    @(posedge clk); #1; rst = 0; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_basic;
    int lat;
    exp_t e;
    out_ready = 1;
    send(12'h123, 12'h456, 1'b1, lat);
    e = exp_q.pop_front();
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", lat); end
    vectors++;
    if ({sum, cout} !== {12'h57A, 1'b0} || {sum, cout} !== {e.s, e.c}) begin
      miscompares++; $display("FAIL basic_sum: got %h/%b want 57a/0", sum, cout);
    end
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++; $display("FAIL basic_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    vectors++;
    if (sum !== 12'h57A) begin miscompares++; $display("FAIL basic_hold_after: got %h want 57a", sum); end
    out_ready = 0;
  endtask
  task automatic test_ripple;
    int lat;
    exp_t e;
    send(12'hFFF, 12'h001, 1'b0, lat);
    e = exp_q.pop_front();
    vectors++;
    if ({sum, cout, lat} !== {12'h000, 1'b1, 32'd4} || {sum, cout} !== {e.s, e.c}) begin
      miscompares++; $display("FAIL ripple: got sum=%h cout=%b lat=%0d want 000/1/4", sum, cout, lat);
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask
  task automatic test_backpressure;
    int lat;
    exp_t e;
    send(12'h0AA, 12'h055, 1'b0, lat);
    e = exp_q.pop_front();
    a = 12'h111; b = 12'h222; cin = 0; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({out_valid, in_ready, sum, cout} !== {1'b1, 1'b0, e.s, e.c}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b sum=%h cout=%b want 1/0/%h/%b", i, out_valid, in_ready, sum, cout, e.s, e.c);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    vectors++;
    if ({in_ready, out_valid, sum} !== {2'b10, 12'h0FF}) begin
      miscompares++; $display("FAIL backpressure_release: got ready=%b valid=%b sum=%h want 1/0/0ff", in_ready, out_valid, sum);
    end
    push_exp(12'h111, 12'h222, 1'b0);
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    vectors++;
    if ({sum, cout, lat} !== {12'h333, 1'b0, 32'd4} || {sum, cout} !== {e.s, e.c}) begin
      miscompares++; $display("FAIL deferred_accept: got sum=%h cout=%b lat=%0d want 333/0/4", sum, cout, lat);
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask
  task automatic test_reset_mid;
    int lat;
    exp_t e;
    a = 12'hFFF; b = 12'hFFF; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1; #1;
    vectors++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 12'h000, 1'b0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL reset_mid: got valid=%b sum=%h cout=%b ovf=%b ready=%b want 0/000/0/0/1", out_valid, sum, cout, ovf, in_ready);
    end
    @(posedge clk); #1; rst = 0;
    send(12'h001, 12'h002, 1'b0, lat);
    e = exp_q.pop_front();
    vectors++;
    if ({sum, cout, lat} !== {12'h003, 1'b0, 32'd4} || {sum, cout} !== {e.s, e.c}) begin
      miscompares++; $display("FAIL after_reset: got sum=%h cout=%b lat=%0d want 003/0/4", sum, cout, lat);
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask
  task automatic test_back_to_back;
    int lat;
    exp_t e;
    logic [11:0] av, bv;
    logic ci;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      av = 12'($urandom_range(0, 4095));
      bv = 12'($urandom_range(0, 4095));
      ci = 1'($urandom_range(0, 1));
      if (i == 0) begin av = 12'hFFF; bv = 12'hFFF; ci = 1; end
      send(av, bv, ci, lat);
      e = exp_q.pop_front();
      vectors++;
      if ({sum, cout, lat} !== {e.s, e.c, 32'd4}) begin
        miscompares++;
        $display("FAIL b2b[%0d] %h+%h+%b: got sum=%h cout=%b lat=%0d want %h/%b/4", i, av, bv, ci, sum, cout, lat, e.s, e.c);
      end
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
`ifdef CHUNK_ADDER_SEQ_OVF_EN
  task automatic test_ovf;
    int lat;
    exp_t e;
    logic [11:0] av[3] = '{12'h7FF, 12'h800, 12'hFFF};
    logic [11:0] bv[3] = '{12'h001, 12'h800, 12'h001};
    logic [13:0] want[3] = '{{12'h800, 1'b0, 1'b1}, {12'h000, 1'b1, 1'b1}, {12'h000, 1'b1, 1'b0}};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(av[i], bv[i], 1'b0, lat);
      e = exp_q.pop_front();
      vectors++;
      if ({sum, cout, ovf} !== want[i] || {sum, cout, ovf} !== {e.s, e.c, e.o}) begin
        miscompares++;
        $display("FAIL ovf[%0d]: got sum=%h cout=%b ovf=%b want %h/%b/%b", i, sum, cout, ovf, want[i][13:2], want[i][1], want[i][0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_ripple;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
`ifdef CHUNK_ADDER_SEQ_OVF_EN
    test_ovf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
